adc_spi_responder: RTL

- Synthesizable model of the 8-channel, 12-bit serial ADC: the device end of the ADC_SCLK / ADC_CS_N / ADC_DIN / ADC_DOUT link.
- Captures the 6-bit configuration word the ADC controller shifts in and shifts the selected channel's 12-bit sample back out, MSB first.
- Pipelined like the real part: each frame returns the channel chosen by the previous frame.
- Sits on the FPGA side in loopback/bench builds, with CH0..CH7 fed from registers or a waveform generator instead of the physical converter.

---
 rtl/adc_spi_pkg.sv | 32 +++
 rtl/adc_spi_responder_sync_edge.sv | 33 +++
 rtl/adc_spi_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/adc_spi_pkg.sv
// Shared constants, state encoding and config decode for the serial ADC responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package adc_spi_pkg;

    localparam int ADC_BITS = 12;
    localparam int CFG_BITS = 6;

    // Config word layout, MSB first on the wire: {S/D, O/S, S1, S0, UNI, SLP}
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    localparam logic [CFG_BITS-1:0] CFG_RESET = 6'b100010;

    localparam int            CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_CFG = 4'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX = 4'(ADC_BITS);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic [2:0] cfg_to_channel(input logic [CFG_BITS-1:0] cfg);
        return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
    endfunction

endpackage

// File: rtl/adc_spi_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with rise/fall pulse outputs.
// Latency: level after STAGES cycles, edge pulses valid during the following cycle.
// Backpressure: none; every input edge produces exactly one pulse.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign level = chain_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// Device side of an 8-channel 12-bit serial ADC: captures config, returns the previously selected channel.
// Latency: SYNC_STAGES+1 clk cycles from any serial input edge to its effect on outputs.
// Backpressure: none; the controller paces the link, clk must run >= 4x SCLK.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                adc_sclk,
    input  logic                adc_cs_n,
    input  logic                adc_din,
    output logic                adc_dout,
    input  logic [ADC_BITS-1:0] ch0,
    input  logic [ADC_BITS-1:0] ch1,
    input  logic [ADC_BITS-1:0] ch2,
    input  logic [ADC_BITS-1:0] ch3,
    input  logic [ADC_BITS-1:0] ch4,
    input  logic [ADC_BITS-1:0] ch5,
    input  logic [ADC_BITS-1:0] ch6,
    input  logic [ADC_BITS-1:0] ch7,
    output logic [CFG_BITS-1:0] cfg_word,
    output logic                cfg_strobe,
    output logic                frame_err
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic din_s;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc_sclk),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // CS_N chain resets low: a frame already running at reset release only ends
    // with a rise seen in IDLE (ignored), so it can never be mistaken for a new frame.
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc_cs_n),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // DIN needs no edge detect; same depth keeps it aligned with the SCLK pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_sync_q <= '0;
        end else begin
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], adc_din};
        end
    end
    assign din_s = din_sync_q[SYNC_STAGES-1];

    logic [ADC_BITS-1:0] ch_arr [8];
    assign ch_arr[0] = ch0;
    assign ch_arr[1] = ch1;
    assign ch_arr[2] = ch2;
    assign ch_arr[3] = ch3;
    assign ch_arr[4] = ch4;
    assign ch_arr[5] = ch5;
    assign ch_arr[6] = ch6;
    assign ch_arr[7] = ch7;

    state_t              state_q, state_d;
    logic [ADC_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CFG_BITS-1:0] cfg_sr_q, cfg_sr_d;
    logic [CFG_BITS-1:0] cfg_word_q, cfg_word_d;
    logic [2:0]          chan_q, chan_d;
    logic                single_q, single_d;
    logic                strobe_q, strobe_d;
    logic                ferr_q, ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            cfg_sr_q   <= '0;
            cfg_word_q <= CFG_RESET;
            chan_q     <= '0;
            single_q   <= 1'b1;
            strobe_q   <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            cfg_sr_q   <= cfg_sr_d;
            cfg_word_q <= cfg_word_d;
            chan_q     <= chan_d;
            single_q   <= single_d;
            strobe_q   <= strobe_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        cfg_sr_d   = cfg_sr_q;
        cfg_word_d = cfg_word_q;
        chan_d     = chan_q;
        single_d   = single_q;
        strobe_d   = 1'b0;
        ferr_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    shift_d = single_q ? ch_arr[chan_q] : '0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                // CS_N rise takes priority over any SCLK edge in the same cycle.
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    shift_d = '0;
                    if (cnt_q >= CNT_CFG) begin
                        cfg_word_d = cfg_sr_q;
                        chan_d     = cfg_to_channel(cfg_sr_q);
                        single_d   = cfg_sr_q[CFG_SD];
                        strobe_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    if (sclk_rise) begin
                        if (cnt_q < CNT_CFG) begin
                            cfg_sr_d = {cfg_sr_q[CFG_BITS-2:0], din_s};
                        end
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                    if (sclk_fall) begin
                        shift_d = {shift_q[ADC_BITS-2:0], 1'b0};
                    end
                end
            end
        endcase
    end

    assign adc_dout   = shift_q[ADC_BITS-1];
    assign cfg_word   = cfg_word_q;
    assign cfg_strobe = strobe_q;
    assign frame_err  = ferr_q;

endmodule
